i2c_cfg_sequencer: RTL and testbench

- Sequences the video-receiver register-init table after reset. Steps a combinational LUT through LUT_INDEX and reads LUT_DATA = {reg_addr, value}.
- Issues one I2C register write per entry to the shared I2C write controller through a req/done handshake.
- Stops at the 16'hFFFF end marker or at LUT_SIZE entries, then reports done or error to the top level.

---
 rtl/i2c_cfg_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// Walks the receiver init LUT and issues one I2C register write per entry.
// Define CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY extra times.
module i2c_cfg_sequencer #(
  parameter logic [7:0]  DEV_ADDR     = 8'h98,
  parameter int          LUT_SIZE     = 42,
  parameter logic [19:0] PWRUP_CYCLES = 20'd1_000_000,
  parameter logic [15:0] GAP_CYCLES   = 16'd1000
`ifdef CFG_RETRY_EN
  ,
  parameter int          MAX_RETRY    = 3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_restart,
  output logic [7:0]  LUT_INDEX,
  input  logic [15:0] LUT_DATA,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  typedef enum logic [2:0] {
    PWRUP, FETCH, ISSUE, WAIT, GAP, DONE, ERROR
  } state_t;

  localparam logic [7:0]  LAST_IDX  = 8'(LUT_SIZE);
  localparam logic [19:0] PWRUP_END = PWRUP_CYCLES - 20'd1;
  localparam logic [19:0] GAP_END   = {4'd0, GAP_CYCLES};

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef CFG_RETRY_EN
  logic [7:0]  retry_q, retry_d;
  logic        pend_q, pend_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    busy_d  = 1'b1;
    done_d  = done_q;
    err_d   = err_q;
`ifdef CFG_RETRY_EN
    retry_d = retry_q;
    pend_d  = pend_q;
`endif
    unique case (state_q)
      PWRUP: begin
        if (cnt_q == PWRUP_END) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      FETCH: begin
        if (LUT_DATA == 16'hFFFF || idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          reg_d   = LUT_DATA[15:8];
          wdata_d = LUT_DATA[7:0];
          state_d = ISSUE;
`ifdef CFG_RETRY_EN
          retry_d = '0;
          pend_d  = 1'b0;
`endif
        end
      end
      ISSUE: begin
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (i2c_done) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (!i2c_nack) begin
            state_d = GAP;
`ifdef CFG_RETRY_EN
          end else if (retry_q < 8'(MAX_RETRY)) begin
            retry_d = retry_q + 8'd1;
            pend_d  = 1'b1;
            state_d = GAP;
`endif
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = FETCH;
`ifdef CFG_RETRY_EN
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = ISSUE;
          end else
`endif
          if (idx_q != LAST_IDX) idx_d = idx_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      DONE, ERROR: begin
        busy_d = 1'b0;
        if (cfg_restart) begin
          state_d = PWRUP;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CFG_RETRY_EN
      retry_q <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CFG_RETRY_EN
      retry_q <= retry_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign LUT_INDEX    = idx_q;
  assign i2c_req      = req_q;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = reg_q;
  assign i2c_wdata    = wdata_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_error    = err_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer with a LUT model and an
// I2C controller model that acks (or NACKs) five cycles after req.
module tb_i2c_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_restart = 1'b0;
  logic [7:0]  LUT_INDEX;
  logic [15:0] LUT_DATA;
  logic        i2c_req;
  logic [7:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_cfg_sequencer #(
    .DEV_ADDR(8'h98),
    .LUT_SIZE(42),
    .PWRUP_CYCLES(20'd10),
    .GAP_CYCLES(16'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_restart(cfg_restart),
    .LUT_INDEX(LUT_INDEX),
    .LUT_DATA(LUT_DATA),
    .i2c_req(i2c_req),
    .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done),
    .i2c_nack(i2c_nack),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_error(cfg_error)
  );

  logic [15:0] lut [0:255];
  logic [7:0]  marker = 8'd42;
  assign LUT_DATA = (LUT_INDEX == marker) ? 16'hFFFF : lut[LUT_INDEX];

  // controller model state; written only by the controller process
  logic       ctrl_done = 1'b0;
  logic       ctrl_nack = 1'b0;
  logic       spur_done = 1'b0;
  logic       active = 1'b0;
  int         ccnt = 0;
  int         nacks_given = 0;
  int         nack_limit = 0;
  logic [7:0] nack_idx = 8'd255;
  int         nwrites = 0;
  int         cyc = 0;
  logic [7:0] log_idx [0:255];
  logic [7:0] log_reg [0:255];
  logic [7:0] log_dat [0:255];
  logic [7:0] log_dev [0:255];
  int         log_cyc [0:255];

  assign i2c_done = ctrl_done | spur_done;
  assign i2c_nack = ctrl_nack | spur_done;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      ctrl_done = 1'b0;
      ctrl_nack = 1'b0;
    end else if (ctrl_done) begin
      ctrl_done = 1'b0;
      ctrl_nack = 1'b0;
      active = 1'b0;
    end else if (active) begin
      ccnt++;
      if (ccnt == 5) begin
        ctrl_done = 1'b1;
        ctrl_nack = (LUT_INDEX == nack_idx) && (nacks_given < nack_limit);
        if (ctrl_nack) nacks_given++;
      end
    end else if (i2c_req) begin
      active = 1'b1;
      ccnt = 0;
      if (nwrites < 256) begin
        log_idx[nwrites] = LUT_INDEX;
        log_reg[nwrites] = i2c_reg_addr;
        log_dat[nwrites] = i2c_wdata;
        log_dev[nwrites] = i2c_dev_addr;
        log_cyc[nwrites] = cyc;
      end
      nwrites++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(cfg_done || cfg_error), 32'd1);
  endtask

  task automatic restart(input string tag);
    @(negedge clk) cfg_restart = 1'b1;
    @(negedge clk) cfg_restart = 1'b0;
    chk({tag, "_rs_done"}, 32'(cfg_done), 32'd0);
    chk({tag, "_rs_idx"}, 32'(LUT_INDEX), 32'd0);
    chk({tag, "_rs_busy"}, 32'(cfg_busy), 32'd1);
  endtask

  // index/field sequence of writes since base must be 0..cnt-1 from the LUT
  task automatic chk_seq(input string tag, input int base, input int cnt);
    int bad = 0;
    for (int k = 0; k < cnt; k++) begin
      if (log_idx[base+k] !== 8'(k)) bad++;
      if ({log_reg[base+k], log_dat[base+k]} !== lut[k]) bad++;
      if (log_dev[base+k] !== 8'h98) bad++;
    end
    chk({tag, "_seq"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    int hits;
    for (int i = 0; i < 256; i++) lut[i] = {8'(8'h41 + i), 8'(i * 3)};
    lut[41] = 16'h2F77;
    lut[42] = 16'h1234;

    repeat (3) @(negedge clk);
    chk("rst_idx", 32'(LUT_INDEX), 32'd0);
    chk("rst_req", 32'(i2c_req), 32'd0);
    chk("rst_reg", 32'(i2c_reg_addr), 32'd0);
    chk("rst_wdata", 32'(i2c_wdata), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_error), 32'd0);
    chk("dev_addr", 32'(i2c_dev_addr), 32'h98);

    // normal run, marker at 42
    rst = 1'b0;
    base = nwrites;
    wait_end("norm");
    chk("norm_writes", 32'(nwrites - base), 32'd42);
    chk("norm_w0", {16'd0, log_reg[base], log_dat[base]}, 32'h4100);
    chk("norm_w41", {16'd0, log_reg[base+41], log_dat[base+41]}, 32'h2F77);
    chk("norm_idx", 32'(LUT_INDEX), 32'd42);
    chk("norm_done", 32'(cfg_done), 32'd1);
    chk("norm_err", 32'(cfg_error), 32'd0);
    chk("norm_busy", 32'(cfg_busy), 32'd0);
    chk("norm_first", 32'(log_cyc[base] >= 10), 32'd1);
    chk("norm_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd13);
    chk_seq("norm", base, 42);

    // no marker: LUT_SIZE bound terminates
    marker = 8'd200;
    restart("size");
    base = nwrites;
    wait_end("size");
    chk("size_writes", 32'(nwrites - base), 32'd42);
    chk("size_idx", 32'(LUT_INDEX), 32'd42);
    chk("size_done", 32'(cfg_done), 32'd1);

    // early marker at 3
    marker = 8'd3;
    restart("early");
    base = nwrites;
    wait_end("early");
    chk("early_writes", 32'(nwrites - base), 32'd3);
    chk("early_idx", 32'(LUT_INDEX), 32'd3);
    chk("early_done", 32'(cfg_done), 32'd1);
    chk_seq("early", base, 3);

    // marker at index 0: zero writes
    marker = 8'd0;
    restart("zero");
    base = nwrites;
    wait_end("zero");
    chk("zero_writes", 32'(nwrites - base), 32'd0);
    chk("zero_idx", 32'(LUT_INDEX), 32'd0);
    chk("zero_done", 32'(cfg_done), 32'd1);
    marker = 8'd42;

`ifndef CFG_RETRY_EN
    nack_idx = 8'd5;
    nack_limit = nacks_given + 1;
    restart("nack");
    base = nwrites;
    wait_end("nack");
    chk("nack_err", 32'(cfg_error), 32'd1);
    chk("nack_done", 32'(cfg_done), 32'd0);
    chk("nack_idx", 32'(LUT_INDEX), 32'd5);
    chk("nack_req", 32'(i2c_req), 32'd0);
    repeat (50) @(negedge clk);
    chk("nack_writes", 32'(nwrites - base), 32'd6);
    chk("nack_hold", 32'(LUT_INDEX), 32'd5);
    restart("rerun");
    base = nwrites;
    wait_end("rerun");
    chk("rerun_writes", 32'(nwrites - base), 32'd42);
    chk("rerun_done", 32'(cfg_done), 32'd1);
    chk_seq("rerun", base, 42);
`else
    nack_idx = 8'd7;
    nack_limit = nacks_given + 2;
    restart("retry");
    base = nwrites;
    wait_end("retry");
    hits = 0;
    for (int k = base; k < nwrites; k++) if (log_idx[k] == 8'd7) hits++;
    chk("retry_hits", 32'(hits), 32'd3);
    chk("retry_writes", 32'(nwrites - base), 32'd44);
    chk("retry_done", 32'(cfg_done), 32'd1);
    nack_limit = nacks_given + 4;
    restart("rfail");
    base = nwrites;
    wait_end("rfail");
    hits = 0;
    for (int k = base; k < nwrites; k++) if (log_idx[k] == 8'd7) hits++;
    chk("rfail_hits", 32'(hits), 32'd4);
    chk("rfail_err", 32'(cfg_error), 32'd1);
    chk("rfail_idx", 32'(LUT_INDEX), 32'd7);
    restart("rerun");
    wait_end("rerun");
`endif

    // restart and spurious done during GAP are ignored
    nack_idx = 8'd255;
    restart("spur");
    base = nwrites;
    n = 0;
    while (!((nwrites - base) == 3 && !active && !i2c_req) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("spur_reach", 32'(n < 1000), 32'd1);
    cfg_restart = 1'b1;
    @(negedge clk) cfg_restart = 1'b0;
    spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    chk("spur_busy", 32'(cfg_busy), 32'd1);
    wait_end("spur");
    chk("spur_writes", 32'(nwrites - base), 32'd42);
    chk("spur_done", 32'(cfg_done), 32'd1);
    chk("spur_err", 32'(cfg_error), 32'd0);
    chk_seq("spur", base, 42);

    // reset while waiting on write at index 10
    restart("mid");
    base = nwrites;
    n = 0;
    while (!((nwrites - base) == 11 && active) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", 32'(n < 1000), 32'd1);
    chk("mid_idx", 32'(LUT_INDEX), 32'd10);
    chk("mid_req", 32'(i2c_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_idx", 32'(LUT_INDEX), 32'd0);
    chk("mrst_req", 32'(i2c_req), 32'd0);
    chk("mrst_reg", 32'(i2c_reg_addr), 32'd0);
    chk("mrst_wdata", 32'(i2c_wdata), 32'd0);
    chk("mrst_busy", 32'(cfg_busy), 32'd0);
    chk("mrst_done", 32'(cfg_done), 32'd0);
    chk("mrst_err", 32'(cfg_error), 32'd0);
    @(negedge clk) rst = 1'b0;
    base = nwrites;
    wait_end("post");
    chk("post_writes", 32'(nwrites - base), 32'd42);
    chk("post_first", 32'(log_idx[base]), 32'd0);
    chk("post_done", 32'(cfg_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
